// File: rtl/sound_mixer_i2s.sv
// sound_mixer_i2s
// ---------------
// Mono audio mixer and I2S transmitter for the 6502 sound subsystem.
// The YM2151 music, POKEY effects and TMS5220 speech streams are each
// scaled by a field of the 6502-written volume register. The three products
// are summed, scaled down by 8 and saturated to 16 bits. The mixed sample is
// latched once per 64-BCLK frame. It is then sent MSB first in both the left
// and right halves of the I2S frame.
//
// Ports:
//   clk100         in   1   system clock (100 MHz)
//   rst            in   1   synchronous reset, active-high
//   vol_wr         in   1   volume register write strobe
//   vol_din        in   8   [7:5] speech vol, [4:3] effects vol, [2:0] music vol
//   ym_sample      in  16   signed music sample
//   pokey_sample   in   8   unsigned effects sample, 0x80 = silence
//   speech_sample  in  10   signed speech sample
//   clip_clr       in   1   clears the sticky clip flag
//   mix_out        out 16   signed mixed sample of the current frame
//   mix_valid      out  1   one-cycle pulse when mix_out updates
//   clip           out  1   sticky saturation flag
//   i2s_bclk       out  1   bit clock (clk100 / 32)
//   i2s_lrclk      out  1   word select, 0 = left
//   i2s_sd         out  1   serial data, MSB first
module sound_mixer_i2s (
  input  logic        clk100,
  input  logic        rst,
  input  logic        vol_wr,
  input  logic [7:0]  vol_din,
  input  logic [15:0] ym_sample,
  input  logic [7:0]  pokey_sample,
  input  logic [9:0]  speech_sample,
  input  logic        clip_clr,
  output logic [15:0] mix_out,
  output logic        mix_valid,
  output logic        clip,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sd
);

  // Register state
  logic [7:0]         vol_q, vol_d;
  logic signed [18:0] ym_p_q, ym_p_d;
  logic signed [18:0] fx_p_q, fx_p_d;
  logic signed [18:0] sp_p_q, sp_p_d;
  logic [15:0]        sum_q, sum_d;
  logic               sat_q, sat_d;
  logic [15:0]        mix_out_q, mix_out_d;
  logic               mix_valid_q, mix_valid_d;
  logic               clip_q, clip_d;
  logic               bclk_q, bclk_d;
  logic               lrclk_q, lrclk_d;
  logic               sd_q, sd_d;
  logic [3:0]         div_q, div_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [15:0]        shift_q, shift_d;

  // Combinational helpers
  logic signed [18:0] ym_ext_s, mv_ext_s;
  logic signed [8:0]  fx_off_s;
  logic signed [18:0] fx_ext_s, fv_ext_s;
  logic signed [18:0] sp_ext_s, sv_ext_s;
  logic signed [20:0] sum_full_s;
  logic signed [20:0] sum_shr_s;
  logic               fall_s;
  logic               latch_s;
  logic [4:0]         slot_s;
  logic [4:0]         bit_pos_s;

  // Volume register: written directly from the 6502 data bus
  always_comb begin
    vol_d = vol_q;
    if (vol_wr) begin
      vol_d = vol_din;
    end else begin
      vol_d = vol_q;
    end
  end

  // Stage 1: per-source products. All operands are widened to 19-bit signed.
  // The volume fields are zero-extended, so they scale without changing sign.
  always_comb begin
    ym_ext_s = {{3{ym_sample[15]}}, ym_sample};
    mv_ext_s = {16'd0, vol_q[2:0]};
    // POKEY is offset-binary: recentre around zero in 9-bit two's complement
    fx_off_s = {1'b0, pokey_sample} - 9'd128;
    fx_ext_s = {{2{fx_off_s[8]}}, fx_off_s, 8'd0};
    fv_ext_s = {17'd0, vol_q[4:3]};
    sp_ext_s = {{3{speech_sample[9]}}, speech_sample, 6'd0};
    sv_ext_s = {16'd0, vol_q[7:5]};
    ym_p_d   = ym_ext_s * mv_ext_s;
    fx_p_d   = fx_ext_s * fv_ext_s;
    sp_p_d   = sp_ext_s * sv_ext_s;
  end

  // Stage 2: 21-bit sum, divide by 8, saturate to 16 bits
  always_comb begin
    sum_full_s = {{2{ym_p_q[18]}}, ym_p_q}
               + {{2{fx_p_q[18]}}, fx_p_q}
               + {{2{sp_p_q[18]}}, sp_p_q};
    sum_shr_s  = sum_full_s >>> 3;
    // The value fits in 16 bits only if bits [20:15] are all sign copies
    if ((&sum_shr_s[20:15]) || (~|sum_shr_s[20:15])) begin
      sat_d = 1'b0;
      sum_d = sum_shr_s[15:0];
    end else if (sum_shr_s[20]) begin
      sat_d = 1'b1;
      sum_d = 16'h8000;
    end else begin
      sat_d = 1'b1;
      sum_d = 16'h7FFF;
    end
  end

  // Bit-clock divider and frame slot counter
  always_comb begin
    div_d  = div_q + 4'd1;
    fall_s = (div_q == 4'd15) && bclk_q;
    if (div_q == 4'd15) begin
      bclk_d = ~bclk_q;
    end else begin
      bclk_d = bclk_q;
    end
    if (fall_s) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    // Frame boundary: the falling edge on which the slot counter wraps to 0
    latch_s = fall_s && (bit_cnt_q == 6'd63);
  end

  // Frame latch, valid pulse and sticky clip flag
  always_comb begin
    mix_valid_d = latch_s;
    if (latch_s) begin
      mix_out_d = sum_q;
      shift_d   = sum_q;
    end else begin
      mix_out_d = mix_out_q;
      shift_d   = shift_q;
    end
    clip_d = clip_q;
    if (clip_clr) begin
      clip_d = 1'b0;
    end else begin
      clip_d = clip_q;
    end
    // A saturating latch overrides a simultaneous clear
    if (latch_s && sat_q) begin
      clip_d = 1'b1;
    end else begin
      clip_d = clip_d;
    end
  end

  // I2S word select and serial data, updated only on BCLK falling edges
  always_comb begin
    slot_s    = bit_cnt_d[4:0];
    bit_pos_s = 5'd16 - slot_s;
    lrclk_d   = lrclk_q;
    sd_d      = sd_q;
    if (fall_s) begin
      lrclk_d = bit_cnt_d[5];
      // Slot 0 of each half is 0 and slots 1..16 carry the sample MSB
      // first; at slot 0 the shift source may still hold the old frame.
      if ((slot_s >= 5'd1) && (slot_s <= 5'd16)) begin
        sd_d = shift_q[bit_pos_s[3:0]];
      end else begin
        sd_d = 1'b0;
      end
    end else begin
      lrclk_d = lrclk_q;
      sd_d    = sd_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk100) begin
    if (rst) begin
      vol_q       <= 8'h00;
      ym_p_q      <= 19'sd0;
      fx_p_q      <= 19'sd0;
      sp_p_q      <= 19'sd0;
      sum_q       <= 16'h0000;
      sat_q       <= 1'b0;
      mix_out_q   <= 16'h0000;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sd_q        <= 1'b0;
      div_q       <= 4'd0;
      bit_cnt_q   <= 6'd0;
      shift_q     <= 16'h0000;
    end else begin
      vol_q       <= vol_d;
      ym_p_q      <= ym_p_d;
      fx_p_q      <= fx_p_d;
      sp_p_q      <= sp_p_d;
      sum_q       <= sum_d;
      sat_q       <= sat_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      clip_q      <= clip_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sd_q        <= sd_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
    end
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign clip      = clip_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sd    = sd_q;

endmodule

// File: tb/tb_sound_mixer_i2s.sv
// Testbench for sound_mixer_i2s. A timeline model checks every output pin
// after every clk100 edge. The model counts edges since reset and derives
// BCLK, slot, word select and the serial bit from that count. Each frame's
// sample is computed with integer arithmetic from the inputs recorded two
// edges before the latch. Directed checks cover the documented mix values,
// clip set/clear priority, a mid-frame volume write and a mid-frame reset.
module tb_sound_mixer_i2s;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic        vol_wr = 1'b0;
  logic [7:0]  vol_din = 8'h00;
  logic [15:0] ym_sample = 16'h0000;
  logic [7:0]  pokey_sample = 8'h80;
  logic [9:0]  speech_sample = 10'h000;
  logic        clip_clr = 1'b0;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic        clip;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sd;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          t_m = 0;
  logic [7:0]  vol_m = 8'h00;
  logic        clip_m = 1'b0;
  logic [15:0] cur_m = 16'h0000;
  logic        lat_m = 1'b0;
  logic [15:0] h_ym[4];
  logic [7:0]  h_pk[4];
  logic [9:0]  h_sp[4];
  logic [7:0]  h_vol[4];

  sound_mixer_i2s dut (
    .clk100(clk100), .rst(rst), .vol_wr(vol_wr), .vol_din(vol_din),
    .ym_sample(ym_sample), .pokey_sample(pokey_sample),
    .speech_sample(speech_sample), .clip_clr(clip_clr),
    .mix_out(mix_out), .mix_valid(mix_valid), .clip(clip),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sd(i2s_sd)
  );

  always #5 clk100 = ~clk100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h time=%0t", tag, obs, exp, $time);
    end
  endtask

  // Mix rule in plain integer arithmetic
  function automatic logic [15:0] mix_ref(input logic [15:0] y, input logic [7:0] p,
                                          input logic [9:0] s, input logic [7:0] v,
                                          output logic sat);
    int m;
    int r;
    m = int'($signed(y)) * int'(v[2:0])
      + (int'(p) - 128) * 256 * int'(v[4:3])
      + int'($signed(s)) * 64 * int'(v[7:5]);
    r = m >>> 3;
    sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      sat = 1'b1;
    end
    return r[15:0];
  endfunction

  // Timeline monitor: advance the model on each edge, compare all pins 1 ns later
  initial begin
    logic sat;
    int idx, slot, n;
    logic [31:0] exp_v;
    logic sd_e;
    forever begin
      @(posedge clk100);
      if (rst) begin
        t_m = 0;
        vol_m = 8'h00;
        clip_m = 1'b0;
        cur_m = 16'h0000;
        lat_m = 1'b0;
      end else begin
        t_m++;
        h_ym[t_m % 4] = ym_sample;
        h_pk[t_m % 4] = pokey_sample;
        h_sp[t_m % 4] = speech_sample;
        h_vol[t_m % 4] = vol_m;
        if (vol_wr) vol_m = vol_din;
        lat_m = (t_m % 2048) == 0;
        sat = 1'b0;
        if (lat_m) begin
          idx = (t_m - 2) % 4;
          cur_m = mix_ref(h_ym[idx], h_pk[idx], h_sp[idx], h_vol[idx], sat);
        end
        if (clip_clr) clip_m = 1'b0;
        if (lat_m && sat) clip_m = 1'b1;
      end
      slot = (t_m >> 5) % 64;
      n = slot % 32;
      sd_e = (n >= 1 && n <= 16) ? cur_m[16 - n] : 1'b0;
      exp_v = {11'd0, lat_m, clip_m, 1'((t_m >> 4) & 1), 1'(slot >= 32), sd_e, cur_m};
      #1;
      check("pins", {11'd0, mix_valid, clip, i2s_bclk, i2s_lrclk, i2s_sd, mix_out}, exp_v);
    end
  end

  task automatic tick();
    @(posedge clk100);
    #2;
  endtask

  task automatic wait_t(input int target);
    int budget;
    budget = 0;
    while (t_m != target && budget < 5000) begin
      tick();
      budget++;
    end
    if (t_m != target) check("wait_t", t_m, target);
  endtask

  task automatic write_vol(input logic [7:0] v);
    vol_wr = 1'b1;
    vol_din = v;
    tick();
    vol_wr = 1'b0;
  endtask

  task automatic pulse_clr();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Music only at full volume
    ym_sample = 16'h4000;
    tick();
    write_vol(8'h07);
    wait_t(2048);
    check("mix_music", mix_out, 16'h3800);
    check("valid_first", mix_valid, 1'b1);

    // Effects at fv = 3, then silent POKEY
    ym_sample = 16'h0000;
    pokey_sample = 8'hFF;
    write_vol(8'h18);
    wait_t(4096);
    check("mix_fx", mix_out, 16'h2FA0);
    pokey_sample = 8'h80;
    wait_t(6144);
    check("mix_silent", mix_out, 16'h0000);

    // Positive saturation, clear, then negative saturation with clear on the latch edge
    ym_sample = 16'h7FFF;
    speech_sample = 10'h1FF;
    write_vol(8'hE7);
    wait_t(8192);
    check("mix_pos_sat", mix_out, 16'h7FFF);
    check("clip_set", clip, 1'b1);
    ym_sample = 16'h8000;
    speech_sample = 10'h200;
    pulse_clr();
    check("clip_clr", clip, 1'b0);
    wait_t(10239);
    pulse_clr();
    check("mix_neg_sat", mix_out, 16'h8000);
    check("clip_set_wins", clip, 1'b1);
    pulse_clr();
    check("clip_clr2", clip, 1'b0);

    // Volume write at slot 20 leaves this frame's bits alone
    wait_t(10240 + 20 * 32);
    write_vol(8'h01);
    wait_t(12288);
    check("mix_after_midwr", mix_out, 16'hF000);

    // Random inputs, volume writes and clears
    repeat (3 * 2048) begin
      ym_sample = 16'($urandom);
      pokey_sample = 8'($urandom);
      speech_sample = 10'($urandom);
      vol_wr = ($urandom_range(0, 99) == 0);
      vol_din = 8'($urandom);
      clip_clr = ($urandom_range(0, 299) == 0);
      tick();
    end
    vol_wr = 1'b0;
    clip_clr = 1'b0;

    // Reset pulsed at slot 40
    wait_t(18432 + 40 * 32);
    ym_sample = 16'h2000;
    pokey_sample = 8'h80;
    speech_sample = 10'h000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mix", mix_out, 16'h0000);
    check("rst_lrclk", i2s_lrclk, 1'b0);
    write_vol(8'h07);
    wait_t(16);
    check("bclk_rise16", i2s_bclk, 1'b1);
    wait_t(2048);
    check("valid_after_rst", mix_valid, 1'b1);
    check("mix_after_rst", mix_out, 16'h1C00);
    repeat (100) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
